muap_arb: RTL and testbench
===========================

# muap_arb

Round-robin arbiter that merges the muap output streams of N_SRC spike-detection instances into one valid/ready muap stream for the downstream packer. Spike detectors have no backpressure (their output ready is tied high), so each source gets a small elastic buffer; words arriving at a full buffer are dropped and counted. The block sits between the per-shank spike detectors and the single muap transfer FIFO.

## Interface
- N_SRC, 4, number of spike-detector sources (2..8)
- BUF_DEPTH, 4, per-source buffer depth in words (power of 2, >=2)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_valid  in  N_SRC  per-source muap strobe, one word per cycle, no ready
- src_frame_No  in  32*N_SRC  frame number t; source i at [32i+31:32i]
- src_ch  in  12*N_SRC  channel; source i at [12i+11:12i]
- src_ch_hash  in  32*N_SRC  channel hash (nearest-neighbour channels)
- src_data  in  32*N_SRC  muap data
- muap_valid  out  1  output word valid
- muap_ready  in  1  downstream accepts word
- muap_frame_No  out  32  frame number of granted word
- muap_ch  out  12  channel
- muap_ch_hash  out  32  channel hash
- muap_data  out  32  muap data
- muap_src  out  $clog2(N_SRC)  index of source the word came from
- ovf  out  N_SRC  sticky per-source overflow flag
- drop_cnt  out  16  saturating count of dropped words, all sources
- drop_clr  in  1  synchronous clear of ovf and drop_cnt

## Operation
- Per-source buffer: BUF_DEPTH-entry FIFO of 108-bit words {frame_No, ch, ch_hash, data}; write pointer, read pointer, occupancy counter 0..BUF_DEPTH.
- Write: src_valid[i] writes buffer i. If buffer i full and not read this cycle: word dropped, ovf[i] set, drop_cnt incremented. Full and read in the same cycle: write accepted, no drop.
- Multiple sources dropping in one cycle: drop_cnt increments by the number of drops; saturates at 16'hFFFF.
- Output register: single stage. Loads when !muap_valid or muap_ready (load enable). On load enable, grant goes to the first non-empty buffer searching from last_grant+1 modulo N_SRC; that buffer is popped and its word plus index loaded; last_grant updated. No non-empty buffer: muap_valid cleared on that edge.
- muap_valid && !muap_ready: all output fields held stable, no pop, last_grant unchanged.
- Arbitration sees buffer contents registered before the current edge; a word written this cycle is not eligible until next cycle.
- drop_clr: clears ovf and drop_cnt; a drop in the same cycle wins (ovf bit set, drop_cnt = number of drops this cycle).
- Reset: all buffers empty, last_grant = N_SRC-1 (source 0 has first priority), muap_valid=0, muap_frame_No/ch/ch_hash/data/src=0, ovf=0, drop_cnt=0.
- Reset asserted mid-operation: buffered and in-flight words discarded; no partial word emitted after release.

## Timing
- Latency: src_valid in cycle t, buffer empty, output idle -> muap_valid high in cycle t+2.
- Throughput: one word per cycle with muap_ready held high; each non-empty source served at least once every N_SRC grants.
- Sustained input above output rate overflows only after BUF_DEPTH words backlog (+1 in the output register).
- ovf and drop_cnt update on the edge ending the drop cycle.
- All outputs registered; no combinational path from src_* or muap_ready to any output.

## Test plan
- Single word: src_valid[2]=1 for one cycle, frame_No=0x100, ch=5, data=0xABCD, ready=1 -> cycle t+2 muap_valid=1, muap_src=2, fields match, one cycle only.
- Fairness: all 4 sources valid in one cycle, ready=1 -> four consecutive outputs muap_src 0,1,2,3; next burst of all four again yields 0,1,2,3.
- Backpressure: ready=0, 3 words into src 1 -> muap_valid=1, fields stable for 10 cycles; ready=1 -> remaining words out in order, frame_No order preserved.
- Overflow: ready=0, 6 consecutive words on src 0 (BUF_DEPTH=4) -> words 1..5 held (1 output + 4 buffer), word 6 dropped, ovf=4'b0001, drop_cnt=1; drop_clr -> both zero.
- Full+read same cycle: buffer 0 full, ready=1, src_valid[0]=1 continuous -> no drops, drop_cnt stays 0.
- Async reset: assert rst_n=0 mid-burst between clock edges -> muap_valid=0 immediately, after release all buffers empty, next src_valid[3] word emerges at t+2 with muap_src=3.

Source files
------------

// File: rtl/muap_arb.sv
// rtl/muap_arb.sv - round-robin merge of N_SRC spike-detector muap streams
// Per-source elastic buffers with drop counting feed one registered valid/ready output.
module muap_arb #(
    parameter int N_SRC     = 4,
    parameter int BUF_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [32*N_SRC-1:0]        src_frame_No,
    input  logic [12*N_SRC-1:0]        src_ch,
    input  logic [32*N_SRC-1:0]        src_ch_hash,
    input  logic [32*N_SRC-1:0]        src_data,
    output logic                       muap_valid,
    input  logic                       muap_ready,
    output logic [31:0]                muap_frame_No,
    output logic [11:0]                muap_ch,
    output logic [31:0]                muap_ch_hash,
    output logic [31:0]                muap_data,
    output logic [$clog2(N_SRC)-1:0]   muap_src,
    output logic [N_SRC-1:0]           ovf,
    output logic [15:0]                drop_cnt,
    input  logic                       drop_clr
);

    localparam int SW = $clog2(N_SRC);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = 108;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

    logic [WW-1:0] mem_q [N_SRC][BUF_DEPTH];
    logic [WW-1:0] mem_d [N_SRC][BUF_DEPTH];
    logic [PW-1:0] wptr_q [N_SRC];
    logic [PW-1:0] wptr_d [N_SRC];
    logic [PW-1:0] rptr_q [N_SRC];
    logic [PW-1:0] rptr_d [N_SRC];
    logic [CW-1:0] cnt_q [N_SRC];
    logic [CW-1:0] cnt_d [N_SRC];

    logic          muap_valid_q, muap_valid_d;
    logic [WW-1:0] out_word_q, out_word_d;
    logic [SW-1:0] muap_src_q, muap_src_d;
    logic [SW-1:0] last_grant_q, last_grant_d;
    logic [N_SRC-1:0] ovf_q, ovf_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic          load_en;
    logic          found;
    logic [SW-1:0] gnt;
    logic [SW-1:0] cand;
    logic [N_SRC-1:0] pop;
    logic [N_SRC-1:0] wr_en;
    logic [N_SRC-1:0] drop;
    logic [3:0]    ndrop;
    logic [16:0]   drop_sum;

    always_comb begin
        load_en = !muap_valid_q || muap_ready;

        // Search starts one past the last grant; only pre-edge occupancy is eligible.
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = SW'((int'(last_grant_q) + k) % N_SRC);
            if (!found && cnt_q[cand] != '0) begin
                found = 1'b1;
                gnt   = cand;
            end
        end

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        pop    = '0;
        wr_en  = '0;
        drop   = '0;
        ndrop  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pop[i]   = load_en && found && (gnt == SW'(i));
            wr_en[i] = src_valid[i] && ((cnt_q[i] != FULL_CNT) || pop[i]);
            drop[i]  = src_valid[i] && (cnt_q[i] == FULL_CNT) && !pop[i];
            if (wr_en[i]) begin
                mem_d[i][wptr_q[i]] = {src_frame_No[32*i +: 32], src_ch[12*i +: 12],
                                       src_ch_hash[32*i +: 32], src_data[32*i +: 32]};
                wptr_d[i] = wptr_q[i] + PW'(1);
            end
            if (pop[i]) begin
                rptr_d[i] = rptr_q[i] + PW'(1);
            end
            cnt_d[i] = cnt_q[i] + {{PW{1'b0}}, wr_en[i]} - {{PW{1'b0}}, pop[i]};
            ndrop    = ndrop + {3'b000, drop[i]};
        end

        muap_valid_d = muap_valid_q;
        out_word_d   = out_word_q;
        muap_src_d   = muap_src_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            if (found) begin
                muap_valid_d = 1'b1;
                out_word_d   = mem_q[gnt][rptr_q[gnt]];
                muap_src_d   = gnt;
                last_grant_d = gnt;
            end else begin
                muap_valid_d = 1'b0;
            end
        end

        // A drop in the clear cycle survives the clear.
        drop_sum = {1'b0, drop_cnt_q} + {13'b0, ndrop};
        if (drop_clr) begin
            ovf_d      = drop;
            drop_cnt_d = {12'b0, ndrop};
        end else begin
            ovf_d      = ovf_q | drop;
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SRC; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
                for (int j = 0; j < BUF_DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
            muap_valid_q <= 1'b0;
            out_word_q   <= '0;
            muap_src_q   <= '0;
            last_grant_q <= SW'(N_SRC - 1);
            ovf_q        <= '0;
            drop_cnt_q   <= '0;
        end else begin
            mem_q        <= mem_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            muap_valid_q <= muap_valid_d;
            out_word_q   <= out_word_d;
            muap_src_q   <= muap_src_d;
            last_grant_q <= last_grant_d;
            ovf_q        <= ovf_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign muap_valid = muap_valid_q;
    assign {muap_frame_No, muap_ch, muap_ch_hash, muap_data} = out_word_q;
    assign muap_src   = muap_src_q;
    assign ovf        = ovf_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_muap_arb.sv
// tb/tb_muap_arb.sv - directed vector bench for muap_arb
module tb_muap_arb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   src_valid = '0;
    logic [127:0] src_frame_No = '0;
    logic [47:0]  src_ch = '0;
    logic [127:0] src_ch_hash = '0;
    logic [127:0] src_data = '0;
    logic         muap_valid;
    logic         muap_ready = 1'b0;
    logic [31:0]  muap_frame_No;
    logic [11:0]  muap_ch;
    logic [31:0]  muap_ch_hash;
    logic [31:0]  muap_data;
    logic [1:0]   muap_src;
    logic [3:0]   ovf;
    logic [15:0]  drop_cnt;
    logic         drop_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    muap_arb #(.N_SRC(4), .BUF_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid),
        .src_frame_No(src_frame_No), .src_ch(src_ch), .src_ch_hash(src_ch_hash),
        .src_data(src_data), .muap_valid(muap_valid), .muap_ready(muap_ready),
        .muap_frame_No(muap_frame_No), .muap_ch(muap_ch), .muap_ch_hash(muap_ch_hash),
        .muap_data(muap_data), .muap_src(muap_src), .ovf(ovf), .drop_cnt(drop_cnt),
        .drop_clr(drop_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sv;
        logic [31:0] base;
        logic        ev;
        logic [1:0]  es;
        logic [31:0] ef;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [11:0] f_ch(input logic [31:0] f);
        return f[11:0] ^ 12'hA5A;
    endfunction

    function automatic logic [31:0] f_data(input logic [31:0] f);
        return {f[15:0], f[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src_valid = '0;
        drop_clr  = 1'b0;
    endtask

    task automatic drive_src(input int i, input logic [31:0] f);
        src_valid[i]            = 1'b1;
        src_frame_No[32*i +: 32] = f;
        src_ch[12*i +: 12]       = f_ch(f);
        src_ch_hash[32*i +: 32]  = ~f;
        src_data[32*i +: 32]     = f_data(f);
    endtask

    task automatic check_out(input string nm, input logic ev, input logic [1:0] es,
                             input logic [31:0] ef);
        chk({nm, ".valid"}, 32'(muap_valid), 32'(ev));
        if (ev) begin
            chk({nm, ".src"},   32'(muap_src), 32'(es));
            chk({nm, ".frame"}, muap_frame_No, ef);
            chk({nm, ".ch"},    32'(muap_ch), 32'(f_ch(ef)));
            chk({nm, ".hash"},  muap_ch_hash, ~ef);
            chk({nm, ".data"},  muap_data, f_data(ef));
        end
    endtask

    task automatic check_drop(input string nm, input logic [3:0] eo, input logic [15:0] ed);
        chk({nm, ".ovf"},  32'(ovf), 32'(eo));
        chk({nm, ".drop"}, 32'(drop_cnt), 32'(ed));
    endtask

    logic [31:0] drain_f [8];
    logic [1:0]  drain_s [8];

    initial begin
        tbl[0]  = '{4'b1111, 32'h100, 1'b0, 2'd0, 32'h0};
        tbl[1]  = '{4'b0000, 32'h0,   1'b1, 2'd0, 32'h100};
        tbl[2]  = '{4'b0000, 32'h0,   1'b1, 2'd1, 32'h101};
        tbl[3]  = '{4'b0000, 32'h0,   1'b1, 2'd2, 32'h102};
        tbl[4]  = '{4'b0000, 32'h0,   1'b1, 2'd3, 32'h103};
        tbl[5]  = '{4'b1111, 32'h200, 1'b0, 2'd0, 32'h0};
        tbl[6]  = '{4'b0000, 32'h0,   1'b1, 2'd0, 32'h200};
        tbl[7]  = '{4'b0000, 32'h0,   1'b1, 2'd1, 32'h201};
        tbl[8]  = '{4'b0000, 32'h0,   1'b1, 2'd2, 32'h202};
        tbl[9]  = '{4'b0000, 32'h0,   1'b1, 2'd3, 32'h203};
        tbl[10] = '{4'b0000, 32'h0,   1'b0, 2'd0, 32'h0};
        tbl[11] = '{4'b0100, 32'h400, 1'b0, 2'd0, 32'h0};
        tbl[12] = '{4'b0001, 32'h500, 1'b1, 2'd2, 32'h402};
        tbl[13] = '{4'b0000, 32'h0,   1'b1, 2'd0, 32'h500};
        tbl[14] = '{4'b0000, 32'h0,   1'b0, 2'd0, 32'h0};
        tbl[15] = '{4'b1010, 32'h600, 1'b0, 2'd0, 32'h0};
        tbl[16] = '{4'b0000, 32'h0,   1'b1, 2'd1, 32'h601};
        tbl[17] = '{4'b0000, 32'h0,   1'b1, 2'd3, 32'h603};
        tbl[18] = '{4'b0000, 32'h0,   1'b0, 2'd0, 32'h0};

        drain_f = '{32'h900, 32'h801, 32'h901, 32'h802, 32'h902, 32'h803, 32'h903, 32'h804};
        drain_s = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};

        // reset state
        tick();
        tick();
        chk("rst.valid", 32'(muap_valid), 32'h0);
        chk("rst.src", 32'(muap_src), 32'h0);
        chk("rst.frame", muap_frame_No, 32'h0);
        check_drop("rst", 4'b0000, 16'h0);
        rst_n = 1'b1;

        // fairness / eligibility table
        muap_ready = 1'b1;
        for (int k = 0; k < 19; k++) begin
            idle();
            for (int i = 0; i < 4; i++)
                if (tbl[k].sv[i]) drive_src(i, tbl[k].base + 32'(i));
            tick();
            check_out($sformatf("vec%0d", k), tbl[k].ev, tbl[k].es, tbl[k].ef);
        end
        idle();
        check_drop("tbl", 4'b0000, 16'h0);

        // single word on source 2, latency t+2, one cycle only
        src_valid[2]          = 1'b1;
        src_frame_No[64 +: 32] = 32'h100;
        src_ch[24 +: 12]       = 12'd5;
        src_ch_hash[64 +: 32]  = 32'h0;
        src_data[64 +: 32]     = 32'hABCD;
        tick();
        idle();
        chk("single.t1.valid", 32'(muap_valid), 32'h0);
        tick();
        chk("single.valid", 32'(muap_valid), 32'h1);
        chk("single.src", 32'(muap_src), 32'h2);
        chk("single.frame", muap_frame_No, 32'h100);
        chk("single.ch", 32'(muap_ch), 32'h5);
        chk("single.data", muap_data, 32'hABCD);
        tick();
        chk("single.t3.valid", 32'(muap_valid), 32'h0);

        // backpressure on source 1
        muap_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_src(1, 32'h700 + 32'(k));
            tick();
            idle();
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            check_out($sformatf("bp.hold%0d", k), 1'b1, 2'd1, 32'h700);
        end
        muap_ready = 1'b1;
        tick();
        check_out("bp.w1", 1'b1, 2'd1, 32'h701);
        tick();
        check_out("bp.w2", 1'b1, 2'd1, 32'h702);
        tick();
        check_out("bp.end", 1'b0, 2'd0, 32'h0);

        // overflow on source 0: 1 output + 4 buffered, sixth dropped
        muap_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_src(0, 32'h800 + 32'(k));
            tick();
            idle();
            chk($sformatf("ovf.w%0d.drop", k), 32'(drop_cnt), (k == 5) ? 32'h1 : 32'h0);
        end
        check_drop("ovf", 4'b0001, 16'h1);
        check_out("ovf.out", 1'b1, 2'd0, 32'h800);
        for (int k = 0; k < 4; k++) begin
            drive_src(2, 32'h900 + 32'(k));
            tick();
            idle();
        end
        check_drop("ovf.fill2", 4'b0001, 16'h1);
        drive_src(0, 32'hDEAD);
        drive_src(2, 32'hBEEF);
        tick();
        idle();
        check_drop("ovf.dual", 4'b0101, 16'h3);
        drive_src(0, 32'hDEAD);
        drop_clr = 1'b1;
        tick();
        idle();
        check_drop("ovf.clr_drop", 4'b0001, 16'h1);
        drop_clr = 1'b1;
        tick();
        idle();
        check_drop("ovf.clr", 4'b0000, 16'h0);
        check_out("ovf.held", 1'b1, 2'd0, 32'h800);
        muap_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_out($sformatf("drain%0d", k), 1'b1, drain_s[k], drain_f[k]);
        end
        tick();
        check_out("drain.end", 1'b0, 2'd0, 32'h0);

        // full buffer written and read in the same cycle
        muap_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_src(0, 32'hA00 + 32'(k));
            tick();
            idle();
        end
        check_out("full.held", 1'b1, 2'd0, 32'hA00);
        muap_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            drive_src(0, 32'hA05 + 32'(j));
            tick();
            idle();
            check_out($sformatf("full.r%0d", j), 1'b1, 2'd0, 32'hA01 + 32'(j));
            chk($sformatf("full.r%0d.drop", j), 32'(drop_cnt), 32'h0);
        end
        chk("full.ovf", 32'(ovf), 32'h0);

        // asynchronous reset mid-burst
        for (int i = 0; i < 4; i++) drive_src(i, 32'hB00 + 32'(i));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(muap_valid), 32'h0);
        chk("arst.src", 32'(muap_src), 32'h0);
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        check_out("arst.post1", 1'b0, 2'd0, 32'h0);
        tick();
        check_out("arst.post2", 1'b0, 2'd0, 32'h0);
        drive_src(3, 32'hC00);
        tick();
        idle();
        check_out("arst.t1", 1'b0, 2'd0, 32'h0);
        tick();
        check_out("arst.t2", 1'b1, 2'd3, 32'hC00);
        tick();
        check_out("arst.t3", 1'b0, 2'd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
